// File: rtl/rv_core_pkg.sv
// ---------------------------------------------------------------------------
// rv_core_pkg
// Shared types and constants for the RV32I core front end.
//   RESET_PC_DEFAULT : bootloader entry address used after reset
//   NOP_INSTR        : addi x0, x0, 0, presented to decode when nothing is held
//   fetch_entry_t    : one {pc, instr} pair as handed from fetch to decode
//   alignWord()      : clears the two byte-offset bits of an address
// ---------------------------------------------------------------------------
package rv_core_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] alignWord(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// ---------------------------------------------------------------------------
// fetch_buf
// Small synchronous FIFO of fetch_entry_t sitting between instruction memory
// and decode. Flush has priority over push and pop and empties the FIFO in
// one edge. The head entry is read combinationally from the read pointer.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   i_push       : write i_pushData at the edge (ignored when full)
//   i_pushData   : entry to write
//   i_pop        : drop the head entry at the edge (ignored when empty)
//   i_flush      : discard all entries, pointers back to 0
//   o_head       : current head entry (undefined contents when empty)
//   o_count      : number of entries held
// ---------------------------------------------------------------------------
module fetch_buf
   import rv_core_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_push,
   input  fetch_entry_t  i_pushData,
   input  logic          i_pop,
   input  logic          i_flush,
   output fetch_entry_t  o_head,
   output logic [CW-1:0] o_count
);

   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [PW-1:0] r_rdPtr;
   logic [PW-1:0] r_wrPtr;
   logic [CW-1:0] r_count;
   fetch_entry_t  r_mem [DEPTH];

   logic w_doPush;
   logic w_doPop;

   // Qualify requests against occupancy so the pointers can never overrun;
   // a flush cancels both so the flush edge leaves a clean empty FIFO.
   always_comb begin
      w_doPush = i_push && !i_flush && (r_count != FULL_COUNT);
      w_doPop  = i_pop  && !i_flush && (r_count != '0);
   end

   // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
   // pointers wrap naturally at their width.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (w_doPush && !w_doPop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_doPush && w_doPop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Storage needs no reset: an entry is only ever read after it was written,
   // and the top masks the head whenever the count is zero.
   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_pushData;
      end
   end

   // Expose the head entry and the occupancy.
   always_comb begin
      o_head  = r_mem[r_rdPtr];
      o_count = r_count;
   end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// RV32I instruction fetch stage. Holds the PC, reads the combinational
// instruction memory, buffers {pc, instr} pairs in fetch_buf and presents the
// head to decode with a valid/ready handshake. Redirects from execute flush
// the buffer and reload the PC; halt stops new fetches while the buffer drains.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   MEM_addr        : word-aligned byte address to instruction memory (= pc)
//   rMEM_en         : read enable, high in every cycle a word is captured
//   MEM_dout        : instruction word for MEM_addr, same cycle
//   redirect_valid  : one-cycle redirect pulse from execute
//   redirect_pc     : redirect target (low bits dropped, flagged if nonzero)
//   halt            : level, suppresses fetching
//   if_valid        : head of buffer valid
//   if_ready        : decode takes the head this cycle
//   if_instr, if_pc : head entry, NOP / 0 when empty
//   fetch_err       : one-cycle pulse after a misaligned redirect
// ---------------------------------------------------------------------------
module instr_fetch
   import rv_core_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] MEM_addr,
   output logic        rMEM_en,
   input  logic [31:0] MEM_dout,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        fetch_err
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(BUF_DEPTH);

   logic [31:0]   r_pc;
   logic          r_fetchErr;

   logic          w_fetch;
   logic          w_pop;
   logic          w_headValid;
   logic [CW-1:0] w_count;
   fetch_entry_t  w_pushData;
   fetch_entry_t  w_head;

   // Fetch gating uses only the registered occupancy, so decode's ready never
   // reaches the memory enable combinationally. A redirect steals the cycle,
   // and a pop in that cycle is dropped because the flush discards the entry.
   always_comb begin
      w_headValid      = (w_count != '0);
      w_fetch          = !reset && !redirect_valid && !halt && (w_count < FULL_COUNT);
      w_pop            = w_headValid && if_ready && !redirect_valid;
      w_pushData.pc    = r_pc;
      w_pushData.instr = MEM_dout;
   end

   fetch_buf #(
      .DEPTH (BUF_DEPTH)
   ) u_fetchBuf (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_fetch),
      .i_pushData (w_pushData),
      .i_pop      (w_pop),
      .i_flush    (redirect_valid),
      .o_head     (w_head),
      .o_count    (w_count)
   );

   // Program counter: redirect wins, otherwise advance by one word on each
   // captured fetch. The 32-bit add wraps past the top of the address space.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc <= RESET_PC;
      end else if (redirect_valid) begin
         r_pc <= alignWord(redirect_pc);
      end else if (w_fetch) begin
         r_pc <= r_pc + 32'd4;
      end
   end

   // A misaligned target is still followed (rounded down) but flagged for one
   // cycle so the trap logic downstream can react.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetchErr <= 1'b0;
      end else begin
         r_fetchErr <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      end
   end

   // Memory port and decode-side outputs; an empty buffer shows a NOP at pc 0.
   always_comb begin
      MEM_addr  = r_pc;
      rMEM_en   = w_fetch;
      if_valid  = w_headValid;
      if_instr  = w_headValid ? w_head.instr : NOP_INSTR;
      if_pc     = w_headValid ? w_head.pc    : 32'h0000_0000;
      fetch_err = r_fetchErr;
   end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. Instruction memory is modelled as
// MEM[i] = i, i.e. the word at byte address A is A >> 2. Each table row sets
// the inputs for one cycle shortly after the rising edge, then compares the
// settled outputs before the next edge. A reset row asserts reset mid-cycle.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic [31:0] MEM_addr;
   logic        rMEM_en;
   logic [31:0] MEM_dout;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        fetch_err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        hlt;
      logic        expEn;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expPc;
      logic [31:0] expInstr;
      logic        expErr;
   } vec_t;

   vec_t vecs[$];

   instr_fetch #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .MEM_addr       (MEM_addr),
      .rMEM_en        (rMEM_en),
      .MEM_dout       (MEM_dout),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .fetch_err      (fetch_err)
   );

   // Combinational instruction memory holding MEM[i] = i.
   assign MEM_dout = {2'b00, MEM_addr[31:2]};

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                               input logic [31:0] rpc, input logic hlt,
                               input logic en, input logic [31:0] addr,
                               input logic valid, input logic [31:0] pc,
                               input logic [31:0] instr, input logic err);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hlt = hlt;
      v.expEn = en; v.expAddr = addr; v.expValid = valid;
      v.expPc = pc; v.expInstr = instr; v.expErr = err;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      reset          = v.rst;
      if_ready       = v.rdy;
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      halt           = v.hlt;
   endtask

   task automatic cmp(input string tag, input string field,
                      input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s.%s got=%0h want=%0h", tag, field, got, want);
      end
   endtask

   task automatic checkOutput(input string tag, input logic en, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc,
                              input logic [31:0] instr, input logic err);
      cmp(tag, "rMEM_en",   {31'b0, rMEM_en},   {31'b0, en});
      cmp(tag, "MEM_addr",  MEM_addr,           addr);
      cmp(tag, "if_valid",  {31'b0, if_valid},  {31'b0, valid});
      cmp(tag, "if_pc",     if_pc,              pc);
      cmp(tag, "if_instr",  if_instr,           instr);
      cmp(tag, "fetch_err", {31'b0, fetch_err}, {31'b0, err});
   endtask

   initial begin
      reset          = 1'b1;
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      halt           = 1'b0;

      //        rst rdy rv rpc            hlt  en addr          v  pc            instr         err
      // Reset state and free run
      vecs.push_back(mk(1, 1, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        NOP,          0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0,        NOP,          0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'h4,        1, 32'h0,        32'h0,        0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'h8,        1, 32'h4,        32'h1,        0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'hC,        1, 32'h8,        32'h2,        0));
      // Back-pressure from a fresh reset: two fetches, then stall for 3 cycles
      vecs.push_back(mk(1, 1, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        NOP,          0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0,        NOP,          0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0,   1, 32'h4,        1, 32'h0,        32'h0,        0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0,   0, 32'h8,        1, 32'h0,        32'h0,        0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0,   0, 32'h8,        1, 32'h0,        32'h0,        0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0,   0, 32'h8,        1, 32'h0,        32'h0,        0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   0, 32'h8,        1, 32'h0,        32'h0,        0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'h8,        1, 32'h4,        32'h1,        0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'hC,        1, 32'h8,        32'h2,        0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0,   1, 32'h10,       1, 32'hC,        32'h3,        0));
      // Redirect to 0xC8 with a full buffer and a concurrent pop
      vecs.push_back(mk(0, 1, 1, 32'hC8,       0,   0, 32'h14,       1, 32'hC,        32'h3,        0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'hC8,       0, 32'h0,        NOP,          0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'hCC,       1, 32'hC8,       32'h32,       0));
      // Misaligned redirect to 0x102
      vecs.push_back(mk(0, 1, 1, 32'h102,      0,   0, 32'hD0,       1, 32'hCC,       32'h33,       0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'h100,      0, 32'h0,        NOP,          1));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'h104,      1, 32'h100,      32'h40,       0));
      // Fill two entries ending at pc 0x20, then halt 3 cycles while draining
      vecs.push_back(mk(0, 1, 1, 32'h18,       0,   0, 32'h108,      1, 32'h104,      32'h41,       0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0,   1, 32'h18,       0, 32'h0,        NOP,          0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0,   1, 32'h1C,       1, 32'h18,       32'h6,        0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        1,   0, 32'h20,       1, 32'h18,       32'h6,        0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        1,   0, 32'h20,       1, 32'h1C,       32'h7,        0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        1,   0, 32'h20,       0, 32'h0,        NOP,          0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'h20,       0, 32'h0,        NOP,          0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'h24,       1, 32'h20,       32'h8,        0));
      // Redirect to 0x40 during halt
      vecs.push_back(mk(0, 1, 0, 32'h0,        1,   0, 32'h28,       1, 32'h24,       32'h9,        0));
      vecs.push_back(mk(0, 1, 1, 32'h40,       1,   0, 32'h28,       0, 32'h0,        NOP,          0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        1,   0, 32'h40,       0, 32'h0,        NOP,          0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'h40,       0, 32'h0,        NOP,          0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'h44,       1, 32'h40,       32'h10,       0));
      // PC wrap from the top word of the address space
      vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 0,  0, 32'h48,       1, 32'h44,       32'h11,       0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'hFFFF_FFFC, 0, 32'h0,       NOP,          0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'h0,        1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'h4,        1, 32'h0,        32'h0,        0));

      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("vec%0d", i), vecs[i].expEn, vecs[i].expAddr,
                     vecs[i].expValid, vecs[i].expPc, vecs[i].expInstr, vecs[i].expErr);
         @(posedge clk);
         #1;
      end

      // Asynchronous reset between edges with two entries buffered.
      if_ready = 1'b0;
      #1;
      checkOutput("bp_fill", 1'b1, 32'h8, 1'b1, 32'h4, 32'h1, 1'b0);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("areset", 1'b0, 32'h0, 1'b0, 32'h0, NOP, 1'b0);
      #2;
      reset    = 1'b0;
      if_ready = 1'b1;
      #1;
      checkOutput("restart", 1'b1, 32'h0, 1'b0, 32'h0, NOP, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("restart_head", 1'b1, 32'h4, 1'b1, 32'h0, 32'h0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the RV32I core, directly upstream of the instruction memory. Holds the program counter, drives the memory's word-addressed read port, captures the returned instruction word, and hands `{pc, instr}` pairs to decode through a valid/ready handshake. A small instruction buffer decouples memory reads from decode back-pressure. Redirects from execute (branch, `jal`, `jalr`, including the bootloader's jump to the application) flush the buffer.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset (bootloader entry).
- `BUF_DEPTH`, default 2: instruction buffer entries; power of two, ≥2.
- `clk  in  1`: core clock.
- `reset  in  1`: asynchronous, active-high reset.
- `MEM_addr  out  32`: byte address to instruction memory; always word-aligned.
- `rMEM_en  out  1`: read enable to instruction memory.
- `MEM_dout  in  32`: instruction word; valid in the same cycle `rMEM_en`/`MEM_addr` are driven (combinational memory read).
- `redirect_valid  in  1`: one-cycle pulse from execute; load a new PC.
- `redirect_pc  in  32`: redirect target.
- `halt  in  1`: level; suppresses new fetches (e.g. `ebreak`). The buffer still drains.
- `if_valid  out  1`: buffer head is valid.
- `if_ready  in  1`: decode accepts the head this cycle.
- `if_instr  out  32`: head instruction; 32'h0000_0013 (NOP) when empty.
- `if_pc  out  32`: head PC; 0 when empty.
- `fetch_err  out  1`: one-cycle pulse on a misaligned redirect.

## Operation
- **State:**
  - `pc` (32 bits)
  - buffer of `BUF_DEPTH` entries `{pc, instr}`, with read pointer, write pointer and count
  - registered `fetch_err`
- **Fetch condition:** `fetch = !reset && !redirect_valid && !halt && (count < BUF_DEPTH)`.
  - `rMEM_en = fetch`.
  - `MEM_addr = pc`.
  - Space is judged on the registered count only. There is no combinational path from `if_ready` to `rMEM_en`.
- **Push:** when `fetch`, write `{pc, MEM_dout}` at the clock edge and set `pc <= pc + 4`. The add wraps modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).
- **Pop:** when `if_valid && if_ready`. Push and pop in the same cycle leave count unchanged.
- **Redirect**, highest priority:
  - flush the buffer (count and both pointers to 0)
  - `pc <= {redirect_pc[31:2], 2'b00}`
  - no fetch and no push that cycle; a concurrent pop is discarded
  - if `redirect_pc[1:0] != 0`, pulse `fetch_err` in the following cycle
- **Halt:** `pc` holds. Fetching resumes the first cycle `halt` is low. A redirect during halt still updates `pc` and flushes.
- **Outputs:**
  - `if_valid = (count != 0)`
  - `if_instr` and `if_pc` come from the head entry, or NOP/0 when empty
- **Reset values:**
  - `pc = RESET_PC`
  - count and pointers = 0
  - `if_valid = 0`, `if_instr = 32'h13`, `if_pc = 0`
  - `rMEM_en = 0`, `fetch_err = 0`
- **Reset mid-operation:** asynchronous assertion clears all state immediately. In-flight buffer contents are lost.

## Timing
- The first fetch is in the first cycle after reset deasserts: `MEM_addr = RESET_PC`, `rMEM_en = 1`.
- Fetch-to-decode latency is 1 cycle: the word fetched in cycle N appears with `if_valid = 1` in cycle N+1.
- With `if_ready` held high, sustained throughput is 1 instruction/cycle and count stays at 1.
- With `if_ready` low, at most `BUF_DEPTH` words are fetched. After that `rMEM_en` stays 0 until a pop frees space, and fetch resumes the cycle after the pop.
- Redirect penalty:
  - redirect in cycle R: no fetch in R
  - target fetched in R+1
  - target valid to decode in R+2
- Redirect in the same cycle as a full buffer plus pop: the redirect wins, and the buffer is empty in R+1.

## Structure
- Shared package `rv_core_pkg`: `RESET_PC_DEFAULT`, `NOP_INSTR = 32'h0000_0013`, and the `fetch_entry_t` struct `{logic [31:0] pc; logic [31:0] instr;}`.
- One sub-module, `fetch_buf`: a synchronous FIFO of `fetch_entry_t` with push, pop, flush, count and asynchronous reset. `instr_fetch` holds the PC logic, fetch gating and redirect priority.

## Test plan
- **Reset and free-run:** memory preloaded with MEM[i] = i, `if_ready` = 1. Required: `MEM_addr` = 0, 4, 8, … on consecutive cycles; `if_pc`/`if_instr` = (0,0), (4,1), (8,2) starting one cycle later.
- **Back-pressure:** `if_ready` = 0 for 5 cycles. Required: exactly 2 fetches (0x0, 0x4), then `rMEM_en` = 0. When ready is restored, the sequence continues 0x4 → 0x8 with no gaps or duplicates.
- **Redirect:** `redirect_valid` with `redirect_pc` = 0xC8 while the buffer holds 2 entries. Required: `if_valid` = 0 the next cycle, `MEM_addr` = 0xC8, and `if_pc` = 0xC8 two cycles after the redirect.
- **Misaligned redirect:** `redirect_pc` = 0x102. Required: `fetch_err` pulses 1 cycle and the next fetch is at 0x100.
- **Halt:** `halt` asserted at pc = 0x20 for 3 cycles. Required: no fetch; the buffer drains to empty; resume at 0x20. A redirect to 0x40 during halt must make the resume address 0x40.
- **Async reset mid-stream:** assert `reset` between edges with 2 entries buffered. Required: `if_valid` = 0 and `rMEM_en` = 0 immediately; after release, fetch restarts at `RESET_PC`.
